// File: rtl/uart_boot_pkg.sv
// Shared types and constants for the UART boot loader frame parser.
// Frame layout byte counts live here so the parser and any tooling agree.
package uart_boot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    LEN,
    DATA,
    WRITE,
    CSUM
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int         ADDR_BYTES        = 4;
  localparam int         LEN_BYTES         = 2;
  localparam int         WORD_BYTES        = 8;

endpackage

// File: rtl/uart_boot_loader.sv
// UART byte stream -> 64-bit memory writes; one write per 8 payload bytes, done one cycle after the last handshake.
// Backpressure: s_axis_tready drops while a write waits for mem_wready. Optional checksum byte: UART_BOOT_CSUM_EN.
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [63:0]           mem_wdata,
  output logic                  mem_wvalid,
  input  logic                  mem_wready,
  output logic                  busy,
  output logic                  done,
  output logic                  csum_error
);

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(7);
  localparam logic [2:0] ADDR_LAST = 3'(ADDR_BYTES - 1);
  localparam logic [2:0] LEN_LAST  = 3'(LEN_BYTES - 1);
  localparam logic [2:0] WORD_LAST = 3'(WORD_BYTES - 1);

  state_t                  state, state_nxt;
  logic [2:0]              cnt;
  logic [23:0]             addr_buf;
  logic [7:0]              len_lo;
  logic [15:0]             words;
  logic                    accept;
  logic                    finish;
  logic [31:0]             addr_full;
  logic [ADDR_WIDTH-1:0]   addr_cast;
  logic [15:0]             len_word;

  assign accept    = s_axis_tvalid && s_axis_tready;
  assign addr_full = {s_axis_tdata, addr_buf};
  assign addr_cast = ADDR_WIDTH'(addr_full);
  assign len_word  = {s_axis_tdata, len_lo};

  always_comb begin
    state_nxt     = state;
    finish        = 1'b0;
    s_axis_tready = (state != WRITE);
    mem_wvalid    = (state == WRITE);
    busy          = (state != IDLE);
    case (state)
      IDLE:  if (accept && s_axis_tdata == SYNC_BYTE) state_nxt = ADDR;
      ADDR:  if (accept && cnt == ADDR_LAST) state_nxt = LEN;
      LEN: begin
        if (accept && cnt == LEN_LAST) begin
          if (len_word == 16'd0) finish = 1'b1;
          else                   state_nxt = DATA;
        end
      end
      DATA:  if (accept && cnt == WORD_LAST) state_nxt = WRITE;
      WRITE: begin
        if (mem_wready) begin
          if (words == 16'd1) finish = 1'b1;
          else                state_nxt = DATA;
        end
      end
      CSUM:    if (accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
`ifdef UART_BOOT_CSUM_EN
    if (finish) state_nxt = CSUM;
`else
    if (finish) state_nxt = IDLE;
`endif
  end

`ifdef UART_BOOT_CSUM_EN
  logic [7:0] csum;
`else
  assign csum_error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_buf  <= '0;
      len_lo    <= '0;
      words     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      done      <= 1'b0;
`ifdef UART_BOOT_CSUM_EN
      csum       <= '0;
      csum_error <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      // Byte counter restarts on every state change, including IDLE->ADDR.
      cnt   <= (state_nxt != state) ? 3'd0 : cnt + 3'(accept);
      case (state)
        ADDR: begin
          if (accept) begin
            addr_buf <= {s_axis_tdata, addr_buf[23:8]};
            if (cnt == ADDR_LAST) mem_addr <= addr_cast & ALIGN_MASK;
          end
        end
        LEN: begin
          if (accept) begin
            len_lo <= s_axis_tdata;
            if (cnt == LEN_LAST) words <= len_word;
          end
        end
        DATA: if (accept) mem_wdata <= {s_axis_tdata, mem_wdata[63:8]};
        WRITE: begin
          if (mem_wready) begin
            mem_addr <= mem_addr + ADDR_WIDTH'(8);
            words    <= words - 16'd1;
          end
        end
        default: ;
      endcase
`ifdef UART_BOOT_CSUM_EN
      csum_error <= 1'b0;
      if (state == IDLE && accept) csum <= '0;
      if (accept && (state == ADDR || state == LEN || state == DATA))
        csum <= csum ^ s_axis_tdata;
      if (state == CSUM && accept) begin
        if (s_axis_tdata == csum) done       <= 1'b1;
        else                      csum_error <= 1'b1;
      end
`else
      if (finish) done <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Directed bench for uart_boot_loader: reset, single/multi-word frames, stalls, junk, N=0, mid-frame reset, wrap.
// Checksum cases are compiled in only with UART_BOOT_CSUM_EN.
module tb_uart_boot_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic [31:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_wvalid;
  logic        mem_wready = 1'b0;
  logic        busy, done, csum_error;

  int checks = 0;
  int failures = 0;

  int stall_n = 0;
  int wait_cnt = 0;
  bit in_write = 0;
  logic [31:0] hold_addr;
  logic [63:0] hold_data;
  int done_cnt = 0, err_cnt = 0, both_err = 0;
  int stall_cyc = 0, stable_err = 0, rdy_err = 0;
  logic [31:0] wr_addr[$];
  logic [63:0] wr_data[$];

  int w0, d0, e0, s0;

  uart_boot_loader #(.ADDR_WIDTH(32), .SYNC_BYTE(8'hA5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wvalid    (mem_wvalid),
    .mem_wready    (mem_wready),
    .busy          (busy),
    .done          (done),
    .csum_error    (csum_error)
  );

  always #5 clk = ~clk;

  // Memory responder and observer; write is logged when ready is raised for the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      mem_wready = 1'b0;
      wait_cnt   = 0;
      in_write   = 0;
    end else begin
      if (done) done_cnt++;
      if (csum_error) err_cnt++;
      if (done && csum_error) both_err++;
      if (mem_wvalid) begin
        mem_wready = (wait_cnt >= stall_n);
        wait_cnt++;
        if (!mem_wready) stall_cyc++;
        if (in_write && (mem_addr !== hold_addr || mem_wdata !== hold_data)) stable_err++;
        if (s_axis_tready) rdy_err++;
        hold_addr = mem_addr;
        hold_data = mem_wdata;
        in_write  = 1;
        if (mem_wready) begin
          wr_addr.push_back(mem_addr);
          wr_data.push_back(mem_wdata);
        end
      end else begin
        mem_wready = 1'b0;
        wait_cnt   = 0;
        in_write   = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok = 0;
    s_axis_tdata  = b;
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        ok = 1;
        break;
      end
    end
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
    if (!ok) chk("byte_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_frame(input logic [31:0] a, input logic [15:0] n,
                            input logic [63:0] wa, input logic [63:0] wb, input bit bad);
    logic [7:0]  cs = 8'h00;
    logic [7:0]  b;
    logic [63:0] wd;
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) begin
      b = a[8*i +: 8];
      cs ^= b;
      send_byte(b);
    end
    for (int i = 0; i < 2; i++) begin
      b = n[8*i +: 8];
      cs ^= b;
      send_byte(b);
    end
    for (int w = 0; w < int'(n); w++) begin
      wd = (w == 0) ? wa : wb;
      for (int k = 0; k < 8; k++) begin
        b = wd[8*k +: 8];
        cs ^= b;
        send_byte(b);
      end
    end
`ifdef UART_BOOT_CSUM_EN
    send_byte(bad ? (cs ^ 8'hFF) : cs);
`else
    if (bad) cs = ~cs;
`endif
  endtask

  task automatic snap;
    w0 = wr_addr.size();
    d0 = done_cnt;
    e0 = err_cnt;
    s0 = stall_cyc;
  endtask

  task automatic wait_end;
    for (int i = 0; i < 60 && done_cnt == d0 && err_cnt == e0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tdata  = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", 64'(s_axis_tready), 64'd1);
    chk("rst_wvalid", 64'(mem_wvalid), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", mem_wdata, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_csum_error", 64'(csum_error), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single word, ready always high
    snap();
    send_frame(32'h0000_1000, 16'd1, 64'h0807060504030201, 64'd0, 0);
    wait_end();
    chk("a_nwrites", 64'(wr_addr.size() - w0), 64'd1);
    chk("a_addr", 64'(wr_addr[w0]), 64'h1000);
    chk("a_data", wr_data[w0], 64'h0807060504030201);
    chk("a_done", 64'(done_cnt - d0), 64'd1);
    chk("a_busy_after", 64'(busy), 64'd0);

    // Two words, unaligned address, 5-cycle stall per write, sync byte inside payload
    stall_n = 5;
    snap();
    send_frame(32'h0000_2004, 16'd2, 64'h11223344A5667788, 64'hDEADBEEFCAFEF00D, 0);
    wait_end();
    stall_n = 0;
    chk("b_nwrites", 64'(wr_addr.size() - w0), 64'd2);
    chk("b_addr0", 64'(wr_addr[w0]), 64'h2000);
    chk("b_data0", wr_data[w0], 64'h11223344A5667788);
    chk("b_addr1", 64'(wr_addr[w0+1]), 64'h2008);
    chk("b_data1", wr_data[w0+1], 64'hDEADBEEFCAFEF00D);
    chk("b_stall_cycles", 64'(stall_cyc - s0), 64'd10);
    chk("b_stable", 64'(stable_err), 64'd0);
    chk("b_tready_in_write", 64'(rdy_err), 64'd0);
    chk("b_done", 64'(done_cnt - d0), 64'd1);

    // Junk before a valid frame
    snap();
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h13);
    chk("j_busy_after_junk", 64'(busy), 64'd0);
    send_frame(32'h0000_3000, 16'd1, 64'h0123456789ABCDEF, 64'd0, 0);
    wait_end();
    chk("j_nwrites", 64'(wr_addr.size() - w0), 64'd1);
    chk("j_addr", 64'(wr_addr[w0]), 64'h3000);
    chk("j_data", wr_data[w0], 64'h0123456789ABCDEF);
    chk("j_done", 64'(done_cnt - d0), 64'd1);

    // Zero-length frame
    snap();
    send_frame(32'h0000_4000, 16'd0, 64'd0, 64'd0, 0);
    wait_end();
    chk("z_nwrites", 64'(wr_addr.size() - w0), 64'd0);
    chk("z_done", 64'(done_cnt - d0), 64'd1);
    chk("z_err", 64'(err_cnt - e0), 64'd0);

    // Reset after third payload byte
    snap();
    send_byte(8'hA5);
    send_byte(8'h00); send_byte(8'h50); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    chk("r_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("r_busy", 64'(busy), 64'd0);
    chk("r_tready", 64'(s_axis_tready), 64'd1);
    chk("r_wvalid", 64'(mem_wvalid), 64'd0);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("r_nwrites", 64'(wr_addr.size() - w0), 64'd0);
    chk("r_done", 64'(done_cnt - d0), 64'd0);
    snap();
    send_frame(32'h0000_5000, 16'd1, 64'hA5A5A5A5A5A5A5A5, 64'd0, 0);
    wait_end();
    chk("r2_addr", 64'(wr_addr[w0]), 64'h5000);
    chk("r2_data", wr_data[w0], 64'hA5A5A5A5A5A5A5A5);
    chk("r2_done", 64'(done_cnt - d0), 64'd1);

    // Address wrap at top of space
    snap();
    send_frame(32'hFFFF_FFF8, 16'd2, 64'h0000000000000001, 64'h0000000000000002, 0);
    wait_end();
    chk("w_nwrites", 64'(wr_addr.size() - w0), 64'd2);
    chk("w_addr0", 64'(wr_addr[w0]), 64'hFFFF_FFF8);
    chk("w_addr1", 64'(wr_addr[w0+1]), 64'h0);
    chk("w_data1", wr_data[w0+1], 64'h2);

`ifdef UART_BOOT_CSUM_EN
    snap();
    send_frame(32'h0000_6000, 16'd1, 64'h1111111122222222, 64'd0, 1);
    wait_end();
    chk("c_bad_nwrites", 64'(wr_addr.size() - w0), 64'd1);
    chk("c_bad_err", 64'(err_cnt - e0), 64'd1);
    chk("c_bad_done", 64'(done_cnt - d0), 64'd0);
    snap();
    send_frame(32'h0000_6000, 16'd1, 64'h1111111122222222, 64'd0, 0);
    wait_end();
    chk("c_good_err", 64'(err_cnt - e0), 64'd0);
    chk("c_good_done", 64'(done_cnt - d0), 64'd1);
`else
    chk("nocsum_err_total", 64'(err_cnt), 64'd0);
`endif

    chk("done_err_exclusive", 64'(both_err), 64'd0);
    chk("idle_busy_end", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
